// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the step-counter width calculation.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must reach BITS/STEP, hence the +1 before taking the log.
  function automatic int cnt_width(input int bits, input int step);
    return $clog2(bits / step + 1);
  endfunction

endpackage

// File: rtl/subtractor_slice.sv
// Combinational WIDTH-bit ripple-borrow subtract slice: diff = a - b - borrow_in.
// Zero latency; no flow control.
module subtractor_slice
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic chain;

  always_comb begin
    chain = borrow_in;
    diff  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ chain;
      chain   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain);
    end
    borrow_out = chain;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, STEP bits per clock, LSB first; result valid BITS/STEP+1 cycles after accept.
// Backpressure: o_ready only in IDLE; DONE holds the result until i_ready.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int BITS = 8,
  parameter int STEP = 1
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [BITS-1:0] i_minuend,
  input  logic [BITS-1:0] i_subtrahend,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_difference,
  output logic            o_borrow,
  output logic            o_zero
);

  localparam int N  = BITS / STEP;
  localparam int CW = cnt_width(BITS, STEP);

  if (STEP < 1 || (BITS % STEP) != 0) begin : g_bad_step
    $error("serial_subtractor: STEP (%0d) must evenly divide BITS (%0d)", STEP, BITS);
  end

  state_t          state;
  state_t          state_nxt;
  logic [BITS-1:0] min_sr;
  logic [BITS-1:0] sub_sr;
  logic [BITS-1:0] res_sr;
  logic [BITS-1:0] res_shift;
  logic            borrow_r;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [STEP-1:0] slice_diff;
  logic            slice_bout;

  subtractor_slice #(
    .WIDTH(STEP)
  ) u_slice (
    .a          (min_sr[STEP-1:0]),
    .b          (sub_sr[STEP-1:0]),
    .borrow_in  (borrow_r),
    .diff       (slice_diff),
    .borrow_out (slice_bout)
  );

  // New slice enters at the MSB so the finished word ends up LSB-aligned.
  if (STEP < BITS) begin : g_shift
    assign res_shift = {slice_diff, res_sr[BITS-1:STEP]};
  end else begin : g_full
    assign res_shift = slice_diff;
  end

  // Every slice is consumed once cnt reaches N; that extra RUN cycle loads the outputs.
  assign last = (cnt == CW'(N));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      min_sr       <= '0;
      sub_sr       <= '0;
      res_sr       <= '0;
      borrow_r     <= 1'b0;
      cnt          <= '0;
      o_difference <= '0;
      o_borrow     <= 1'b0;
      o_zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            min_sr   <= i_minuend;
            sub_sr   <= i_subtrahend;
            borrow_r <= 1'b0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (last) begin
            o_difference <= res_sr;
            o_borrow     <= borrow_r;
            o_zero       <= (res_sr == '0);
          end else begin
            min_sr   <= min_sr >> STEP;
            sub_sr   <= sub_sr >> STEP;
            res_sr   <= res_shift;
            borrow_r <= slice_bout;
            cnt      <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
